instr_encoder: RTL

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/riscv_pkg.sv | 56 +++++
 rtl/instr_encoder_if.sv | 57 +++++
 rtl/instr_pack.sv | 81 ++++++++
 rtl/instr_encoder.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// ----------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the instruction encoder block:
//   - datapath widths used by the encoder interface
//   - fmt_e      : field-bundle format codes presented on fmt_i
//   - OPC_*      : RV32I major opcodes emitted in instr_o[6:0]
//   - state_e    : load-sequencer FSM encoding (IDLE / RUN / DONE)
//   - satInc8()  : saturating 8-bit increment used by the error counter
// ----------------------------------------------------------------------------
package riscv_pkg;

    localparam int XLEN     = 32;
    localparam int COUNT_W  = 16;
    localparam int ERRCNT_W = 8;

    // Format codes as delivered by the field decoder; code 7 is reserved
    // and always rejected.
    typedef enum logic [2:0] {
        FMT_R       = 3'd0,
        FMT_LOAD    = 3'd1,
        FMT_STORE   = 3'd2,
        FMT_OPIMM   = 3'd3,
        FMT_BRANCH  = 3'd4,
        FMT_JAL     = 3'd5,
        FMT_JALR    = 3'd6,
        FMT_ILLEGAL = 3'd7
    } fmt_e;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // Load sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // The error counter sticks at its maximum instead of wrapping, so a
    // long run of bad bundles never reads back as "few errors".
    function automatic logic [ERRCNT_W-1:0] satInc8(input logic [ERRCNT_W-1:0] value);
        logic [ERRCNT_W-1:0] result;
        if (value == {ERRCNT_W{1'b1}}) begin
            result = value;
        end else begin
            result = value + 1'b1;
        end
        return result;
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// ----------------------------------------------------------------------------
// instr_encoder_if
// Bundles every non-clock/reset signal of the instruction encoder.
//   Load control : start_i, base_i, count_i
//   Field input  : valid_i / ready_o handshake carrying fmt_i, rd_i, rs1_i,
//                  rs2_i, funct3_i, funct7_i, imm_i
//   Word output  : instr_valid_o / instr_ready_i handshake carrying
//                  instr_o and addr_o
//   Status       : done_o (pulse), err_o (sticky), err_cnt_o (saturating)
// Modports:
//   master : the side that drives the load (decoder / testbench)
//   slave  : the encoder itself
// ----------------------------------------------------------------------------
interface instr_encoder_if;

    import riscv_pkg::*;

    logic                start_i;
    logic [XLEN-1:0]     base_i;
    logic [COUNT_W-1:0]  count_i;

    logic                valid_i;
    logic                ready_o;
    logic [2:0]          fmt_i;
    logic [4:0]          rd_i;
    logic [4:0]          rs1_i;
    logic [4:0]          rs2_i;
    logic [2:0]          funct3_i;
    logic [6:0]          funct7_i;
    logic [XLEN-1:0]     imm_i;

    logic [XLEN-1:0]     instr_o;
    logic [XLEN-1:0]     addr_o;
    logic                instr_valid_o;
    logic                instr_ready_i;

    logic                done_o;
    logic                err_o;
    logic [ERRCNT_W-1:0] err_cnt_o;

    modport master (
        output start_i, base_i, count_i,
        output valid_i, fmt_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i,
        output instr_ready_i,
        input  ready_o, instr_o, addr_o, instr_valid_o,
        input  done_o, err_o, err_cnt_o
    );

    modport slave (
        input  start_i, base_i, count_i,
        input  valid_i, fmt_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i,
        input  instr_ready_i,
        output ready_o, instr_o, addr_o, instr_valid_o,
        output done_o, err_o, err_cnt_o
    );

endinterface

// File: rtl/instr_pack.sv
// ----------------------------------------------------------------------------
// instr_pack
// Purely combinational field packer. Turns one decoder-style field bundle
// into a 32-bit RV32I instruction word and flags whether the bundle can be
// encoded at all.
// Ports:
//   fmt_i      : format code (riscv_pkg::fmt_e values)
//   rd_i, rs1_i, rs2_i, funct3_i, funct7_i : raw register/function fields
//   imm_i      : immediate; branch and JAL values are in halfword units
//   instr_o    : packed instruction word (zero when not legal)
//   legal_o    : 1 when the format is known and the immediate fits
// ----------------------------------------------------------------------------
module instr_pack
    import riscv_pkg::*;
(
    input  logic [2:0]      fmt_i,
    input  logic [4:0]      rd_i,
    input  logic [4:0]      rs1_i,
    input  logic [4:0]      rs2_i,
    input  logic [2:0]      funct3_i,
    input  logic [6:0]      funct7_i,
    input  logic [XLEN-1:0] imm_i,
    output logic [XLEN-1:0] instr_o,
    output logic            legal_o
);

    logic imm12Fits;
    logic imm20Fits;

    // An immediate is encodable only if every bit above its field width is
    // a copy of the field's sign bit. JAL carries a 20-bit field, every
    // other immediate format carries 12 bits.
    assign imm12Fits = (imm_i[31:11] == {21{imm_i[11]}});
    assign imm20Fits = (imm_i[31:19] == {13{imm_i[19]}});

    // Field placement per format. Fields a format does not use are left at
    // zero rather than passed through, so the emitted words are canonical.
    // Branch and JAL immediates arrive already divided by two, which is why
    // their bit positions are shifted by one compared with the textbook
    // byte-offset tables.
    always_comb begin
        instr_o = '0;
        legal_o = 1'b0;
        case (fmt_e'(fmt_i))
            FMT_R: begin
                instr_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, OPC_R};
                legal_o = 1'b1;
            end
            FMT_LOAD: begin
                instr_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, OPC_LOAD};
                legal_o = imm12Fits;
            end
            FMT_OPIMM: begin
                instr_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, OPC_OPIMM};
                legal_o = imm12Fits;
            end
            FMT_JALR: begin
                instr_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, OPC_JALR};
                legal_o = imm12Fits;
            end
            FMT_STORE: begin
                instr_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], OPC_STORE};
                legal_o = imm12Fits;
            end
            FMT_BRANCH: begin
                instr_o = {imm_i[11], imm_i[9:4], rs2_i, rs1_i, funct3_i,
                           imm_i[3:0], imm_i[10], OPC_BRANCH};
                legal_o = imm12Fits;
            end
            FMT_JAL: begin
                instr_o = {imm_i[19], imm_i[9:0], imm_i[10], imm_i[18:11], rd_i, OPC_JAL};
                legal_o = imm20Fits;
            end
            default: begin
                instr_o = '0;
                legal_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// ----------------------------------------------------------------------------
// instr_encoder
// Sequences a program load: after start_i it accepts count_i legal field
// bundles, encodes each through instr_pack, and hands the words with their
// byte addresses to the instruction-memory writer through a one-entry
// output register. Illegal bundles are swallowed and counted.
// Ports:
//   clk_i : rising-edge clock
//   rst_i : asynchronous, active-high reset
//   bus   : instr_encoder_if.slave (load control, field input handshake,
//           word output handshake, status)
// ----------------------------------------------------------------------------
module instr_encoder
    import riscv_pkg::*;
(
    input logic            clk_i,
    input logic            rst_i,
    instr_encoder_if.slave bus
);

    state_e              state_q, state_d;
    logic [XLEN-1:0]     addr_q, addr_d;
    logic [XLEN-1:0]     instr_q, instr_d;
    logic                instrValid_q, instrValid_d;
    logic [COUNT_W-1:0]  remain_q, remain_d;
    logic [COUNT_W-1:0]  toAccept_q, toAccept_d;
    logic                err_q, err_d;
    logic [ERRCNT_W-1:0] errCnt_q, errCnt_d;

    logic [XLEN-1:0]     packedInstr;
    logic                packLegal;
    logic                readyInt;
    logic                acceptFire;
    logic                downFire;

    instr_pack u_pack (
        .fmt_i    (bus.fmt_i),
        .rd_i     (bus.rd_i),
        .rs1_i    (bus.rs1_i),
        .rs2_i    (bus.rs2_i),
        .funct3_i (bus.funct3_i),
        .funct7_i (bus.funct7_i),
        .imm_i    (bus.imm_i),
        .instr_o  (packedInstr),
        .legal_o  (packLegal)
    );

    // Handshake qualifiers. We can take a new bundle whenever the output
    // register is empty or is being drained this very cycle, which gives
    // one word per cycle when downstream keeps instr_ready_i high. The
    // toAccept counter stops us taking more legal words than were asked
    // for; it only moves on legal words, so rejected bundles never eat
    // into the program length.
    always_comb begin
        readyInt   = (state_q == ST_RUN)
                     && (!instrValid_q || bus.instr_ready_i)
                     && (toAccept_q != '0);
        acceptFire = readyInt && bus.valid_i;
        downFire   = instrValid_q && bus.instr_ready_i;
    end

    // Next-state logic for the sequencer and all datapath registers.
    // The address counter always holds the address of the word sitting in
    // (or about to enter) the output register, so it only advances when a
    // word leaves downstream. In RUN a drain and a fresh accept in the same
    // cycle both take effect: the drain clears valid first and the accept
    // then reloads it. The last drain (remain == 1) moves us to DONE, which
    // lasts exactly one cycle and drives the done pulse.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        instr_d      = instr_q;
        instrValid_d = instrValid_q;
        remain_d     = remain_q;
        toAccept_d   = toAccept_q;
        err_d        = err_q;
        errCnt_d     = errCnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start_i) begin
                    addr_d     = bus.base_i & 32'hFFFF_FFFC;
                    remain_d   = bus.count_i;
                    toAccept_d = bus.count_i;
                    err_d      = 1'b0;
                    errCnt_d   = '0;
                    if (bus.count_i == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                if (downFire) begin
                    addr_d       = addr_q + 32'd4;
                    remain_d     = remain_q - 1'b1;
                    instrValid_d = 1'b0;
                    if (remain_q == {{(COUNT_W-1){1'b0}}, 1'b1}) begin
                        state_d = ST_DONE;
                    end
                end
                if (acceptFire) begin
                    if (packLegal) begin
                        instr_d      = packedInstr;
                        instrValid_d = 1'b1;
                        toAccept_d   = toAccept_q - 1'b1;
                    end else begin
                        err_d    = 1'b1;
                        errCnt_d = satInc8(errCnt_q);
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset is asynchronous so a load that is
    // aborted mid-flight drops its pending word at once and nothing is
    // emitted after the reset edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            instr_q      <= '0;
            instrValid_q <= 1'b0;
            remain_q     <= '0;
            toAccept_q   <= '0;
            err_q        <= 1'b0;
            errCnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            instr_q      <= instr_d;
            instrValid_q <= instrValid_d;
            remain_q     <= remain_d;
            toAccept_q   <= toAccept_d;
            err_q        <= err_d;
            errCnt_q     <= errCnt_d;
        end
    end

    // Outputs come straight from registers or from the state, so they all
    // read zero as soon as reset asserts.
    assign bus.ready_o       = readyInt;
    assign bus.instr_o       = instr_q;
    assign bus.addr_o        = addr_q;
    assign bus.instr_valid_o = instrValid_q;
    assign bus.done_o        = (state_q == ST_DONE);
    assign bus.err_o         = err_q;
    assign bus.err_cnt_o     = errCnt_q;

endmodule
